// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: two-port (CPU, DMA) arbiter in front of a single
// synchronous-read data memory. Grants are combinational from the requests
// and the registered owner state; read data returns one cycle after the
// transfer, tagged to the owner registered at the transfer.
// Optional starvation guard for the DMA port: define ARB_STARVE_GUARD_EN.
module dmem_port_arbiter #(
   parameter int unsigned ADDR_W       = 14,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   // CPU port
   input  logic              cpu_req,
   input  logic [3:0]        cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   // DMA port
   input  logic              dma_req,
   input  logic              dma_lock,
   input  logic [3:0]        dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   // memory side
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CPU_OWN    = 2'd1,
      DMA_OWN    = 2'd2,
      DMA_LOCKED = 2'd3
   } state_t;

   state_t state;
   logic   starve_force;

   // A zero limit would force a DMA grant on every blocked cycle.
   if (STARVE_LIMIT < 1) begin : g_limit_check
      $error("dmem_port_arbiter: STARVE_LIMIT must be at least 1");
   end

`ifdef ARB_STARVE_GUARD_EN
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt;

   assign starve_force = (starve_cnt == CNT_W'(STARVE_LIMIT));

   // Saturating count of cycles the DMA waits while requesting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (!dma_req || dma_gnt) begin
         starve_cnt <= '0;
      end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end
`else
   assign starve_force = 1'b0;
`endif

   // Grant selection: burst lock, then starvation override, then CPU priority.
   always_comb begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      if (rst) begin
         if (state == DMA_LOCKED) begin
            dma_gnt = dma_req;
         end else if (dma_req && (!cpu_req || starve_force)) begin
            dma_gnt = 1'b1;
         end else begin
            cpu_gnt = cpu_req;
         end
      end
   end

   // Steer the granted requester onto the memory port, zeros when idle.
   always_comb begin
      mem_en   = 1'b0;
      mem_we   = 4'b0000;
      mem_addr = '0;
      mem_din  = '0;
      if (cpu_gnt) begin
         mem_en   = 1'b1;
         mem_we   = cpu_we;
         mem_addr = cpu_addr;
         mem_din  = cpu_wdata;
      end else if (dma_gnt) begin
         mem_en   = 1'b1;
         mem_we   = dma_we;
         mem_addr = dma_addr;
         mem_din  = dma_wdata;
      end
   end

   // Owner state and one-cycle read-return flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cpu_rvalid <= 1'b0;
         dma_rvalid <= 1'b0;
      end else begin
         cpu_rvalid <= cpu_gnt && (cpu_we == 4'b0000);
         dma_rvalid <= dma_gnt && (dma_we == 4'b0000);
         if (dma_gnt) begin
            if (dma_lock) begin
               state <= DMA_LOCKED;
            end else if (state == DMA_LOCKED) begin
               state <= IDLE;
            end else begin
               state <= DMA_OWN;
            end
         end else if (cpu_gnt) begin
            state <= CPU_OWN;
         end else begin
            state <= IDLE;
         end
      end
   end

   assign cpu_rdata = cpu_rvalid ? mem_dout : '0;
   assign dma_rdata = dma_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a bench-side sync-read memory.
module tb_dmem_port_arbiter;

   localparam int unsigned ADDR_W       = 14;
   localparam int unsigned DATA_W       = 32;
   localparam int unsigned STARVE_LIMIT = 8;

   logic              clk;
   logic              rst;
   logic              cpu_req;
   logic [3:0]        cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              dma_req;
   logic              dma_lock;
   logic [3:0]        dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_gnt;
   logic              dma_rvalid;
   logic [DATA_W-1:0] dma_rdata;
   logic              mem_en;
   logic [3:0]        mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;

   typedef struct packed {
      logic              dma;
      logic [DATA_W-1:0] data;
   } sb_t;

   sb_t         sb[$];
   logic [31:0] ram[256];
   logic [31:0] shadow[256];
   int          n_chk;
   int          n_bad;

   dmem_port_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_gnt   (cpu_gnt),
      .cpu_rvalid(cpu_rvalid),
      .cpu_rdata (cpu_rdata),
      .dma_req   (dma_req),
      .dma_lock  (dma_lock),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_gnt   (dma_gnt),
      .dma_rvalid(dma_rvalid),
      .dma_rdata (dma_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int a);
      logic [7:0] lo;
      lo = 8'(a);
      return {16'hC0DE, lo, ~lo};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Synchronous-read memory model with byte-masked writes.
   always @(posedge clk) begin
      if (mem_en) begin
         mem_dout <= ram[mem_addr[7:0]];
         for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_din[8*b +: 8];
         end
      end
   end

   // Read-return monitor: pops the scoreboard on every rvalid.
   always @(negedge clk) begin
      sb_t e;
      if (!cpu_rvalid) chk("cpu_rdata_idle", cpu_rdata, 32'h0);
      if (!dma_rvalid) chk("dma_rdata_idle", dma_rdata, 32'h0);
      if (cpu_rvalid || dma_rvalid) begin
         chk("rv_exclusive", 32'(cpu_rvalid & dma_rvalid), 32'h0);
         if (sb.size() == 0) begin
            chk("rv_unexpected", 32'h1, 32'h0);
         end else begin
            e = sb.pop_front();
            chk("rv_owner", 32'(dma_rvalid), 32'(e.dma));
            chk("rv_data", dma_rvalid ? dma_rdata : cpu_rdata, e.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_req   = 1'b0;
      cpu_we    = 4'b0000;
      cpu_addr  = '0;
      cpu_wdata = '0;
      dma_req   = 1'b0;
      dma_lock  = 1'b0;
      dma_we    = 4'b0000;
      dma_addr  = '0;
      dma_wdata = '0;
   endtask

   task automatic write_shadow(input int a, input logic [3:0] we, input logic [31:0] d);
      for (int b = 0; b < 4; b++) begin
         if (we[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1);
   end

   initial begin
      n_chk = 0;
      n_bad = 0;
      for (int i = 0; i < 256; i++) begin
         ram[i]    = pat(i);
         shadow[i] = pat(i);
      end
      mem_dout = '0;
      rst = 1'b0;
      idle_inputs();

      // Reset: requests are ignored, memory port quiet.
      tick();
      cpu_req = 1'b1;
      dma_req = 1'b1;
      #1;
      chk("rst_cpu_gnt", 32'(cpu_gnt), 32'h0);
      chk("rst_dma_gnt", 32'(dma_gnt), 32'h0);
      chk("rst_mem_en", 32'(mem_en), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'h0);
      tick();
      idle_inputs();
      rst = 1'b1;

      // CPU read alone, granted immediately.
      cpu_req  = 1'b1;
      cpu_addr = 14'h0010;
      #1;
      chk("rd_cpu_gnt", 32'(cpu_gnt), 32'h1);
      chk("rd_dma_gnt", 32'(dma_gnt), 32'h0);
      chk("rd_mem_en", 32'(mem_en), 32'h1);
      chk("rd_mem_addr", 32'(mem_addr), 32'h0010);
      chk("rd_mem_we", 32'(mem_we), 32'h0);
      sb.push_back('{dma: 1'b0, data: shadow[16'h10]});
      tick();
      idle_inputs();
      #1;
      chk("rd_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
      chk("rd_cpu_rdata", cpu_rdata, pat(16'h10));
      chk("rd_dma_rvalid", 32'(dma_rvalid), 32'h0);
      chk("idle_mem_en", 32'(mem_en), 32'h0);
      chk("idle_mem_addr", 32'(mem_addr), 32'h0);
      tick();

      // Contention: CPU byte write wins, DMA read follows.
      cpu_req   = 1'b1;
      cpu_we    = 4'b0011;
      cpu_addr  = 14'h0020;
      cpu_wdata = 32'h1234_5678;
      dma_req   = 1'b1;
      dma_addr  = 14'h0030;
      #1;
      chk("wr_cpu_gnt", 32'(cpu_gnt), 32'h1);
      chk("wr_dma_gnt", 32'(dma_gnt), 32'h0);
      chk("wr_mem_we", 32'(mem_we), 32'h3);
      chk("wr_mem_din", mem_din, 32'h1234_5678);
      write_shadow(16'h20, 4'b0011, 32'h1234_5678);
      tick();
      cpu_req = 1'b0;
      cpu_we  = 4'b0000;
      #1;
      chk("wr_no_rvalid", 32'(cpu_rvalid), 32'h0);
      chk("dma_after_gnt", 32'(dma_gnt), 32'h1);
      chk("dma_after_addr", 32'(mem_addr), 32'h0030);
      sb.push_back('{dma: 1'b1, data: shadow[16'h30]});
      tick();
      idle_inputs();
      #1;
      chk("dma_rvalid", 32'(dma_rvalid), 32'h1);
      // Read back the masked write.
      cpu_req  = 1'b1;
      cpu_addr = 14'h0020;
      sb.push_back('{dma: 1'b0, data: shadow[16'h20]});
      tick();
      idle_inputs();
      tick();
      chk("mask_readback", shadow[16'h20], {pat(16'h20) >> 16, 16'h5678});

      // DMA burst lock holds off the CPU.
      dma_req   = 1'b1;
      dma_lock  = 1'b1;
      dma_we    = 4'b1111;
      dma_addr  = 14'h0040;
      dma_wdata = 32'hDEAD_0040;
      #1;
      chk("lk_first_gnt", 32'(dma_gnt), 32'h1);
      write_shadow(16'h40, 4'b1111, 32'hDEAD_0040);
      tick();
      cpu_req  = 1'b1;
      cpu_addr = 14'h0044;
      for (int i = 1; i <= 3; i++) begin
         dma_addr  = 14'(16'h40 + i);
         dma_wdata = 32'hDEAD_0040 + 32'(i);
         #1;
         chk("lk_hold_dma", 32'(dma_gnt), 32'h1);
         chk("lk_hold_cpu", 32'(cpu_gnt), 32'h0);
         write_shadow(16'h40 + i, 4'b1111, 32'hDEAD_0040 + 32'(i));
         tick();
      end
      dma_lock  = 1'b0;
      dma_addr  = 14'h0050;
      dma_wdata = 32'hBEEF_0050;
      #1;
      chk("lk_last_dma", 32'(dma_gnt), 32'h1);
      write_shadow(16'h50, 4'b1111, 32'hBEEF_0050);
      tick();
      #1;
      chk("lk_release_cpu", 32'(cpu_gnt), 32'h1);
      chk("lk_release_dma", 32'(dma_gnt), 32'h0);
      sb.push_back('{dma: 1'b0, data: shadow[16'h44]});
      tick();
      idle_inputs();
      tick();
      chk("lk_written", shadow[16'h43], 32'hDEAD_0043);

      // Both requesting continuously: DMA starves unless guarded.
      cpu_req  = 1'b1;
      cpu_addr = 14'h0060;
      dma_req  = 1'b1;
      dma_addr = 14'h0061;
      for (int c = 1; c <= 20; c++) begin
         logic exp_dma;
`ifdef ARB_STARVE_GUARD_EN
         exp_dma = ((c % (STARVE_LIMIT + 1)) == 0);
`else
         exp_dma = 1'b0;
`endif
         #1;
         chk("st_dma_gnt", 32'(dma_gnt), 32'(exp_dma));
         chk("st_cpu_gnt", 32'(cpu_gnt), 32'(!exp_dma));
         if (exp_dma) sb.push_back('{dma: 1'b1, data: shadow[16'h61]});
         else         sb.push_back('{dma: 1'b0, data: shadow[16'h60]});
         tick();
      end
      idle_inputs();
      tick();
      tick();
      chk("st_drain", 32'(sb.size()), 32'h0);

      // Reset during an in-flight read drops it.
      cpu_req  = 1'b1;
      cpu_addr = 14'h0070;
      #1;
      chk("ar_cpu_gnt", 32'(cpu_gnt), 32'h1);
      rst = 1'b0;
      #1;
      chk("ar_mem_en", 32'(mem_en), 32'h0);
      chk("ar_cpu_gnt_rst", 32'(cpu_gnt), 32'h0);
      tick();
      chk("ar_rvalid_rst", 32'(cpu_rvalid), 32'h0);
      idle_inputs();
      rst = 1'b1;
      #1;
      chk("ar_rvalid_rel", 32'(cpu_rvalid), 32'h0);
      tick();
      chk("ar_rvalid_later", 32'(cpu_rvalid), 32'h0);
      dma_req  = 1'b1;
      dma_addr = 14'h0071;
      #1;
      chk("ar_idle_dma_gnt", 32'(dma_gnt), 32'h1);
      sb.push_back('{dma: 1'b1, data: shadow[16'h71]});
      tick();
      idle_inputs();
      tick();

      // Back-to-back reads alternating between the two ports.
      for (int i = 0; i < 8; i++) begin
         logic is_dma;
         is_dma   = (i % 2) == 1;
         cpu_req  = !is_dma;
         cpu_addr = 14'h0004;
         dma_req  = is_dma;
         dma_addr = 14'h0008;
         #1;
         chk("alt_gnt", 32'({cpu_gnt, dma_gnt}), is_dma ? 32'h1 : 32'h2);
         sb.push_back('{dma: is_dma, data: is_dma ? shadow[16'h08] : shadow[16'h04]});
         tick();
         chk("alt_cpu_rvalid", 32'(cpu_rvalid), 32'(!is_dma));
         chk("alt_dma_rvalid", 32'(dma_rvalid), 32'(is_dma));
      end
      idle_inputs();
      tick();
      tick();
      chk("sb_drain", 32'(sb.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
